// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers decoded operands/control, forwards EX/MEM and MEM/WB
// results onto the ALU operand buses, and handles load-use stalls and branch flushes.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [31:0] id_rd_data1,
    input  logic [31:0] id_rd_data2,
    input  logic [31:0] id_imm,
    input  logic        id_alu_src,
    input  logic [3:0]  id_alu_control,
    input  logic [4:0]  id_dest,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        ex_flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_dest,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_dest,
    input  logic [31:0] memwb_result,
    output logic [31:0] Read_data1,
    output logic [31:0] Read_data2,
    output logic [3:0]  ALU_Control,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic [4:0]  ex_dest,
    output logic [31:0] ex_store_data,
    output logic        stall
);

    logic        valid_q, valid_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic        alu_src_q, alu_src_d;
    logic [3:0]  alu_control_q, alu_control_d;
    logic [4:0]  dest_q, dest_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;

    logic        hz;
    logic        load_id;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    always_comb begin
        hz = valid_q & mem_read_q & (dest_q != 5'd0) & id_valid &
             ((dest_q == id_rs) | (dest_q == id_rt));
        load_id = ~ex_flush & ~hz & id_valid;
    end

    // Anything other than a clean capture of a valid instruction becomes an all-zero bubble.
    always_comb begin
        valid_d       = 1'b0;
        rs_d          = 5'd0;
        rt_d          = 5'd0;
        a_d           = 32'd0;
        b_d           = 32'd0;
        imm_d         = 32'd0;
        alu_src_d     = 1'b0;
        alu_control_d = 4'd0;
        dest_d        = 5'd0;
        reg_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        if (load_id) begin
            valid_d       = 1'b1;
            rs_d          = id_rs;
            rt_d          = id_rt;
            a_d           = id_rd_data1;
            b_d           = id_rd_data2;
            imm_d         = id_imm;
            alu_src_d     = id_alu_src;
            alu_control_d = id_alu_control;
            dest_d        = id_dest;
            reg_write_d   = id_reg_write;
            mem_read_d    = id_mem_read;
            // The register file is read before WB commits, so bypass the write in flight.
            if (memwb_reg_write && (memwb_dest != 5'd0) && (memwb_dest == id_rs)) begin
                a_d = memwb_result;
            end
            if (memwb_reg_write && (memwb_dest != 5'd0) && (memwb_dest == id_rt)) begin
                b_d = memwb_result;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            rs_q          <= 5'd0;
            rt_q          <= 5'd0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            imm_q         <= 32'd0;
            alu_src_q     <= 1'b0;
            alu_control_q <= 4'd0;
            dest_q        <= 5'd0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            imm_q         <= imm_d;
            alu_src_q     <= alu_src_d;
            alu_control_q <= alu_control_d;
            dest_q        <= dest_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB.
    always_comb begin
        if (exmem_reg_write && (exmem_dest != 5'd0) && (exmem_dest == rs_q)) begin
            fwd_a = exmem_result;
        end else if (memwb_reg_write && (memwb_dest != 5'd0) && (memwb_dest == rs_q)) begin
            fwd_a = memwb_result;
        end else begin
            fwd_a = a_q;
        end
        if (exmem_reg_write && (exmem_dest != 5'd0) && (exmem_dest == rt_q)) begin
            fwd_b = exmem_result;
        end else if (memwb_reg_write && (memwb_dest != 5'd0) && (memwb_dest == rt_q)) begin
            fwd_b = memwb_result;
        end else begin
            fwd_b = b_q;
        end
    end

    assign Read_data1    = fwd_a;
    assign Read_data2    = alu_src_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign ALU_Control   = alu_control_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_dest       = dest_q;
    assign stall         = hz & ~ex_flush;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expectations are queued as stimulus is driven and
// compared once the DUT has produced the corresponding output.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic [31:0] id_rd_data1, id_rd_data2, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_control;
    logic        id_reg_write, id_mem_read, ex_flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_dest, memwb_dest;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] Read_data1, Read_data2, ex_store_data;
    logic [3:0]  ALU_Control;
    logic        ex_valid, ex_reg_write, ex_mem_read, stall;
    logic [4:0]  ex_dest;

    localparam int SelRd1   = 0;
    localparam int SelRd2   = 1;
    localparam int SelAlu   = 2;
    localparam int SelValid = 3;
    localparam int SelRw    = 4;
    localparam int SelMr    = 5;
    localparam int SelDest  = 6;
    localparam int SelStore = 7;
    localparam int SelStall = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd_data1     (id_rd_data1),
        .id_rd_data2     (id_rd_data2),
        .id_imm          (id_imm),
        .id_alu_src      (id_alu_src),
        .id_alu_control  (id_alu_control),
        .id_dest         (id_dest),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_flush        (ex_flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .Read_data1      (Read_data1),
        .Read_data2      (Read_data2),
        .ALU_Control     (ALU_Control),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_dest         (ex_dest),
        .ex_store_data   (ex_store_data),
        .stall           (stall)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SelRd1:   return Read_data1;
            SelRd2:   return Read_data2;
            SelAlu:   return {28'd0, ALU_Control};
            SelValid: return {31'd0, ex_valid};
            SelRw:    return {31'd0, ex_reg_write};
            SelMr:    return {31'd0, ex_mem_read};
            SelDest:  return {27'd0, ex_dest};
            SelStore: return ex_store_data;
            default:  return {31'd0, stall};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        drain();
    endtask

    task automatic push_all_zero(input string tag);
        push({tag, "_rd1"}, SelRd1, 32'd0);
        push({tag, "_rd2"}, SelRd2, 32'd0);
        push({tag, "_alu"}, SelAlu, 32'd0);
        push({tag, "_valid"}, SelValid, 32'd0);
        push({tag, "_rw"}, SelRw, 32'd0);
        push({tag, "_mr"}, SelMr, 32'd0);
        push({tag, "_dest"}, SelDest, 32'd0);
        push({tag, "_store"}, SelStore, 32'd0);
        push({tag, "_stall"}, SelStall, 32'd0);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic src, input logic [3:0] alu, input logic [4:0] dest,
                          input logic rw, input logic mr);
        id_valid       = v;
        id_rs          = rs;
        id_rt          = rt;
        id_rd_data1    = d1;
        id_rd_data2    = d2;
        id_imm         = imm;
        id_alu_src     = src;
        id_alu_control = alu;
        id_dest        = dest;
        id_reg_write   = rw;
        id_mem_read    = mr;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] ed, input logic [31:0] er,
                           input logic mw, input logic [4:0] md, input logic [31:0] mres);
        exmem_reg_write = ew;
        exmem_dest      = ed;
        exmem_result    = er;
        memwb_reg_write = mw;
        memwb_dest      = md;
        memwb_result    = mres;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ex_flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        #3;
        push_all_zero("reset");
        drain();
        @(negedge clk);
        rst = 1'b0;

        // Pass-through, register operand B
        set_id(1, 3, 4, 32'h10, 32'h20, 32'h0, 0, 4'b0010, 9, 1, 0);
        push("pt_rd1", SelRd1, 32'h10);
        push("pt_rd2", SelRd2, 32'h20);
        push("pt_alu", SelAlu, 32'h2);
        push("pt_valid", SelValid, 32'h1);
        push("pt_dest", SelDest, 32'd9);
        push("pt_rw", SelRw, 32'h1);
        push("pt_stall", SelStall, 32'h0);
        step();

        // Pass-through, immediate operand B
        set_id(1, 3, 4, 32'h10, 32'h20, 32'hFFFF_FFFC, 1, 4'b0010, 9, 1, 0);
        push("imm_rd2", SelRd2, 32'hFFFF_FFFC);
        push("imm_store", SelStore, 32'h20);
        push("imm_rd1", SelRd1, 32'h10);
        step();

        // Forward priority on operand A
        set_id(1, 5, 6, 32'h55, 32'h66, 32'h0, 0, 4'b0001, 10, 1, 0);
        push("fa_cap", SelRd1, 32'h55);
        step();
        set_fwd(1, 5, 32'hDEAD_BEEF, 1, 5, 32'h1);
        push("fa_exmem_wins", SelRd1, 32'hDEAD_BEEF);
        drain();
        set_fwd(0, 5, 32'hDEAD_BEEF, 1, 5, 32'h1);
        push("fa_memwb", SelRd1, 32'h1);
        drain();
        set_fwd(1, 0, 32'hDEAD_BEEF, 1, 0, 32'h1);
        push("fa_r0_none", SelRd1, 32'h55);
        push("fb_none", SelRd2, 32'h66);
        drain();
        set_fwd(0, 0, 0, 1, 6, 32'h600D);
        push("fb_memwb_rd2", SelRd2, 32'h600D);
        push("fb_memwb_store", SelStore, 32'h600D);
        drain();
        set_fwd(0, 0, 0, 0, 0, 0);

        // Load-use: stall one cycle, bubble, then capture with WB value
        set_id(1, 1, 2, 32'h0, 32'h0, 32'h0, 0, 4'b0010, 8, 1, 1);
        push("lw_mr", SelMr, 32'h1);
        push("lw_dest", SelDest, 32'd8);
        step();
        set_id(1, 8, 9, 32'h0, 32'h99, 32'h0, 0, 4'b0110, 11, 1, 0);
        push("lu_stall", SelStall, 32'h1);
        drain();
        push("lu_bubble_valid", SelValid, 32'h0);
        push("lu_bubble_rw", SelRw, 32'h0);
        push("lu_bubble_alu", SelAlu, 32'h0);
        push("lu_stall_drop", SelStall, 32'h0);
        step();
        set_fwd(0, 0, 0, 1, 8, 32'h1234);
        push("lu_rd1", SelRd1, 32'h1234);
        push("lu_rd2", SelRd2, 32'h99);
        push("lu_valid", SelValid, 32'h1);
        push("lu_alu", SelAlu, 32'h6);
        push("lu_nostall", SelStall, 32'h0);
        step();
        set_fwd(0, 0, 0, 0, 0, 0);

        // Flush and load-use in the same cycle
        set_id(1, 1, 2, 32'h0, 32'h0, 32'h0, 0, 4'b0010, 8, 1, 1);
        push("fl_lw_mr", SelMr, 32'h1);
        step();
        set_id(1, 8, 8, 32'h0, 32'h0, 32'h0, 0, 4'b0010, 12, 1, 0);
        ex_flush = 1'b1;
        push("fl_stall", SelStall, 32'h0);
        drain();
        push("fl_valid", SelValid, 32'h0);
        push("fl_rw", SelRw, 32'h0);
        step();
        ex_flush = 1'b0;

        // Capture bypass from MEM/WB with a stale register-file value
        set_id(1, 7, 0, 32'h0, 32'h0, 32'h0, 0, 4'b0000, 12, 1, 0);
        set_fwd(0, 0, 0, 1, 7, 32'hCAFE_0000);
        step();
        set_fwd(0, 0, 0, 0, 0, 0);
        push("byp_rd1", SelRd1, 32'hCAFE_0000);
        drain();

        // Register 0 is never bypassed or forwarded
        set_id(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 4'b0001, 13, 1, 0);
        set_fwd(1, 0, 32'hBAD0, 1, 0, 32'hBAD1);
        push("r0_rd1", SelRd1, 32'h0);
        push("r0_rd2", SelRd2, 32'h0);
        step();
        set_fwd(0, 0, 0, 0, 0, 0);

        // Invalid decode loads a bubble
        set_id(0, 3, 4, 32'h10, 32'h20, 32'h0, 0, 4'b0010, 9, 1, 0);
        push_all_zero("inv");
        step();

        // Asynchronous reset in the middle of a stall
        set_id(1, 1, 2, 32'h0, 32'h0, 32'h0, 0, 4'b0111, 8, 1, 1);
        push("rs_lw_valid", SelValid, 32'h1);
        step();
        set_id(1, 2, 8, 32'h0, 32'h0, 32'h0, 0, 4'b0010, 14, 1, 0);
        push("rs_pre_stall", SelStall, 32'h1);
        drain();
        rst = 1'b1;
        push_all_zero("midrst");
        drain();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage feeding the ALU of the 32-bit MIPS core. It registers decoded operands and control, and forwards EX/MEM and MEM/WB results onto the ALU operand buses. It detects load-use hazards, stalling the front end and inserting a bubble, and applies branch flushes. Its outputs `Read_data1`, `Read_data2` and `ALU_Control` drive the ALU directly.

## Interface
- No parameters; data width is fixed at 32 bits and register addresses at 5 bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: one clock; reset is asynchronous and active-high.
- `id_valid`  in  1  decode holds a valid instruction.
- `id_rs`, `id_rt`  in  5  source register numbers.
- `id_rd_data1`, `id_rd_data2`  in  32  register-file read values for rs and rt.
- `id_imm`  in  32  sign-extended immediate.
- `id_alu_src`  in  1  when 1, operand B is the immediate.
- `id_alu_control`  in  4  ALU opcode (0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt, 1100 nor).
- `id_dest`  in  5  destination register.
- `id_reg_write`  in  1  instruction writes a register.
- `id_mem_read`  in  1  instruction is a load.
- `ex_flush`  in  1  branch/jump taken; kill the instruction being captured.
- `exmem_reg_write`  in  1  write-enable from EX/MEM.
- `exmem_dest`  in  5  destination from EX/MEM.
- `exmem_result`  in  32  result from EX/MEM.
- `memwb_reg_write`  in  1  write-enable from MEM/WB.
- `memwb_dest`  in  5  destination from MEM/WB.
- `memwb_result`  in  32  result from MEM/WB.
- `Read_data1`, `Read_data2`  out  32  ALU operands A and B.
- `ALU_Control`  out  4  ALU opcode.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`  out  1  registered control.
- `ex_dest`  out  5  registered destination.
- `ex_store_data`  out  32  forwarded rt value, used for stores.
- `stall`  out  1  hold PC and IF/ID this cycle.

## Operation
- **Stage registers:** valid, rs, rt, a, b, imm, alu_src, alu_control, dest, reg_write, mem_read.
- **Bubble:** all stage registers zero; `ALU_Control` is 0000.
- **Load-use hazard:** `hz = ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==id_rs | ex_dest==id_rt)`.
- **Stall output:** `stall = hz & ~ex_flush`, combinational.
- **Capture priority each edge:**
  1. `ex_flush` loads a bubble.
  2. Otherwise, `hz` loads a bubble.
  3. Otherwise, load the ID fields; if `id_valid=0`, load a bubble.
- **Capture bypass:**
  - If `memwb_reg_write & memwb_dest!=0 & memwb_dest==id_rs`, register a captures `memwb_result` instead of `id_rd_data1`.
  - Same rule for rt into register b.
- **Forwarding, combinational from registered rs/rt:** `fwdA` is, in priority order:
  1. `exmem_result` if `exmem_reg_write & exmem_dest!=0 & exmem_dest==rs`.
  2. Else `memwb_result` under the same rule with the MEM/WB fields.
  3. Else register a.
- `fwdB` uses the same rules with rt and register b.
- **Outputs:**
  - `Read_data1 = fwdA`.
  - `Read_data2 = alu_src ? imm : fwdB`.
  - `ex_store_data = fwdB` always.
- Register 0 is never forwarded or bypassed.

## Timing
- Capture to outputs: 1 cycle. Forwarding adds no latency; it is combinational within the EX cycle.
- **Reset:** all stage registers clear asynchronously. While `rst`=1 and at release:
  - `Read_data1`/`Read_data2`/`ex_store_data` are 0 unless forwarding is active, since rs=rt=0 disables forwarding.
  - `ALU_Control`=0000.
  - `ex_valid`/`ex_reg_write`/`ex_mem_read`=0 and `ex_dest`=0.
  - `stall`=0.
- A reset mid-stall drops `stall` immediately because `ex_valid` goes to 0.
- **Load-use sequence:**
  - Cycle N: `stall`=1.
  - Edge N+1: a bubble enters, and the dependent instruction stays in ID.
  - Cycle N+1: `stall`=0.
  - Edge N+2: the dependent instruction is captured. The load is then in WB, so the value arrives via MEM/WB forwarding.
- A stall lasts exactly one cycle per load.
- **Flush and stall together:** flush wins, `stall`=0, and a bubble is loaded.
- When EX/MEM and MEM/WB target the same register, EX/MEM wins.

## Test plan
- **Reset:** pulse `rst` mid-stream with `ex_valid`=1 → all outputs 0 and `ALU_Control`=0000 without waiting for a clock.
- **Pass-through:**
  - Stimulus: rs=3, data1=0x10, rt=4, data2=0x20, `alu_control`=0010, `alu_src`=0, no forwarding.
  - Next cycle: `Read_data1`=0x10, `Read_data2`=0x20, `ALU_Control`=0010.
  - Repeat with `alu_src`=1 and imm=0xFFFFFFFC → `Read_data2`=0xFFFFFFFC, `ex_store_data`=0x20.
- **Forward priority:**
  - Stimulus: registered rs=5; EX/MEM writes r5=0xDEADBEEF; MEM/WB writes r5=0x1 → `Read_data1`=0xDEADBEEF.
  - Drop EX/MEM → `Read_data1`=0x1.
  - Set both dests to 0 → captured value.
- **Load-use:**
  - Stimulus: `lw` with dest=8 in EX; ID has rs=8.
  - Response: `stall`=1 for one cycle, then `ex_valid`=0 for one cycle, then the instruction is captured.
  - With MEM/WB r8=0x1234, `Read_data1`=0x1234.
- **Flush vs stall:** load-use hazard and `ex_flush`=1 in the same cycle → `stall`=0 and the next cycle shows a bubble (`ex_valid`=0, `ex_reg_write`=0).
- **Capture bypass:** MEM/WB writes r7=0xCAFE0000 in the same cycle that ID captures rs=7 with stale `id_rd_data1`=0 → next cycle `Read_data1`=0xCAFE0000 with no forwarding active.
